// File: rtl/fsm_pkg.sv
// Shared types and constants for the 1011 serial sequence detector.
// Encodings 5..7 of state_e are unreachable; the detector sends them back to IDLE.
package fsm_pkg;

  localparam logic [3:0] PATTERN = 4'b1011;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1011 = 3'd4
  } state_e;

  function automatic logic is_match(input state_e s);
    return s == S1011;
  endfunction

endpackage

// File: rtl/fsm.sv
// Moore detector for serial pattern 1011 (first bit first), overlapping matches allowed.
// detected_o is decoded from the state register only, so it cannot glitch on in_i.
module fsm
  import fsm_pkg::*;
(
  input  logic clk,
  input  logic reset_i,
  input  logic in_i,
  output logic detected_o
);

  state_e state;
  state_e next_state;

  always_ff @(posedge clk or negedge reset_i) begin
    // NOTE: non-blocking so the register takes the value next_state held before the edge.
    if (!reset_i) state <= IDLE;
    else          state <= next_state;
  end

  // Each state expects the next PATTERN bit; on a miss it falls back to the
  // longest suffix of what was seen that is still a prefix of 1011.
  always_comb begin
    // NOTE: default first so no path leaves next_state unassigned and infers a latch.
    next_state = IDLE;
    case (state)
      IDLE:  next_state = (in_i == PATTERN[3]) ? S1    : IDLE;
      S1:    next_state = (in_i == PATTERN[2]) ? S10   : S1;
      S10:   next_state = (in_i == PATTERN[1]) ? S101  : IDLE;
      S101:  next_state = (in_i == PATTERN[0]) ? S1011 : S10;
      S1011: next_state = in_i                 ? S1    : S10;
      default: next_state = IDLE;
    endcase
  end

  assign detected_o = is_match(state);

endmodule

// File: tb/tb_fsm.sv
// Directed self-checking bench for the 1011 sequence detector.
// Inputs change on the falling edge; detected_o is sampled 1 ns after each rising edge.
module tb_fsm;

  logic clk;
  logic reset_i;
  logic in_i;
  logic detected_o;

  int pass_cnt;
  int total_cnt;

  fsm dut (
    .clk        (clk),
    .reset_i    (reset_i),
    .in_i       (in_i),
    .detected_o (detected_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic shift(input logic b);
    @(negedge clk);
    in_i = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b0;
    in_i    = 1'b0;
    @(negedge clk);
    reset_i = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] seq;
    seq = 4'b1011;
    #1;
    total_cnt++;
    if (detected_o !== 1'b0)
      $display("FAIL reset_initial: detected_o=%b expected 0", detected_o);
    else pass_cnt++;
    for (int i = 3; i >= 0; i--) begin
      @(negedge clk);
      in_i = seq[i];
      @(posedge clk);
      #1;
      total_cnt++;
      if (detected_o !== 1'b0)
        $display("FAIL reset_hold step %0d: detected_o=%b expected 0", 3 - i, detected_o);
      else pass_cnt++;
    end
    @(negedge clk);
    in_i    = 1'b0;
    reset_i = 1'b1;
  endtask

  task automatic test_single();
    logic [4:0] seq, exp;
    seq = 5'b10110;
    exp = 5'b00010;
    for (int i = 4; i >= 0; i--) begin
      shift(seq[i]);
      total_cnt++;
      if (detected_o !== exp[i])
        $display("FAIL single step %0d: detected_o=%b expected %b", 4 - i, detected_o, exp[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_clear();
    logic [3:0] seq;
    do_reset();
    seq = 4'b1011;
    for (int i = 3; i >= 0; i--) shift(seq[i]);
    total_cnt++;
    if (detected_o !== 1'b1)
      $display("FAIL async_clear_pre: detected_o=%b expected 1", detected_o);
    else pass_cnt++;
    #2;
    reset_i = 1'b0;
    #1;
    total_cnt++;
    if (detected_o !== 1'b0)
      $display("FAIL async_clear: detected_o=%b expected 0", detected_o);
    else pass_cnt++;
    @(negedge clk);
    reset_i = 1'b1;
  endtask

  task automatic test_overlap();
    logic [7:0] seq, exp;
    do_reset();
    seq = 8'b10110110;
    exp = 8'b00010010;
    for (int i = 7; i >= 0; i--) begin
      shift(seq[i]);
      total_cnt++;
      if (detected_o !== exp[i])
        $display("FAIL overlap step %0d: detected_o=%b expected %b", 7 - i, detected_o, exp[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_near_miss();
    logic [5:0] seq, exp;
    logic [3:0] ones;
    do_reset();
    seq = 6'b101011;
    exp = 6'b000001;
    for (int i = 5; i >= 0; i--) begin
      shift(seq[i]);
      total_cnt++;
      if (detected_o !== exp[i])
        $display("FAIL near_miss step %0d: detected_o=%b expected %b", 5 - i, detected_o, exp[i]);
      else pass_cnt++;
    end
    do_reset();
    ones = 4'b1111;
    for (int i = 3; i >= 0; i--) begin
      shift(ones[i]);
      total_cnt++;
      if (detected_o !== 1'b0)
        $display("FAIL all_ones step %0d: detected_o=%b expected 0", 3 - i, detected_o);
      else pass_cnt++;
    end
  endtask

  task automatic test_mid_reset();
    logic [2:0] seq;
    do_reset();
    seq = 3'b101;
    for (int i = 2; i >= 0; i--) begin
      shift(seq[i]);
      total_cnt++;
      if (detected_o !== 1'b0)
        $display("FAIL mid_reset_prefix step %0d: detected_o=%b expected 0", 2 - i, detected_o);
      else pass_cnt++;
    end
    #2;
    reset_i = 1'b0;
    #1;
    total_cnt++;
    if (detected_o !== 1'b0)
      $display("FAIL mid_reset_assert: detected_o=%b expected 0", detected_o);
    else pass_cnt++;
    @(negedge clk);
    reset_i = 1'b1;
    shift(1'b1);
    total_cnt++;
    if (detected_o !== 1'b0)
      $display("FAIL mid_reset_resume: detected_o=%b expected 0", detected_o);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq, exp;
    do_reset();
    seq = 8'b10111011;
    exp = 8'b00010001;
    for (int i = 7; i >= 0; i--) begin
      shift(seq[i]);
      total_cnt++;
      if (detected_o !== exp[i])
        $display("FAIL back_to_back step %0d: detected_o=%b expected %b", 7 - i, detected_o, exp[i]);
      else pass_cnt++;
    end
    shift(1'b0);
    total_cnt++;
    if (detected_o !== 1'b0)
      $display("FAIL back_to_back_tail: detected_o=%b expected 0", detected_o);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset_i   = 1'b0;
    in_i      = 1'b0;
    test_reset();
    test_single();
    test_async_clear();
    test_overlap();
    test_near_miss();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
